// File: rtl/dino_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dino_motion_ctrl: per-frame dino position and animation-select control.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dino_motion_ctrl #(
  parameter logic [9:0] DINO_X      = 10'd40,
  parameter logic [8:0] GROUND_Y    = 9'd300,
  parameter logic [8:0] DUCK_OFFSET = 9'd34,
  parameter logic [6:0] JUMP_V      = 7'd20,
  parameter logic [3:0] STEP_FRAMES = 4'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       jump_btn,
  input  logic       duck_btn,
  input  logic       collide,
  output logic [9:0] DinoX,
  output logic [8:0] DinoY,
  output logic [3:0] AnimateSel,
  output logic       is_dead,
  output logic       running
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_JUMP = 3'd2,
    S_DUCK = 3'd3,
    S_DEAD = 3'd4
  } state_t;

  localparam logic [3:0] C_SEL_DEFAULT = 4'b0000;
  localparam logic [3:0] C_SEL_DEAD    = 4'b0001;
  localparam logic [3:0] C_SEL_RUNL    = 4'b0011;
  localparam logic [3:0] C_SEL_RUNR    = 4'b0111;
  localparam logic [3:0] C_SEL_DUCKL   = 4'b0010;
  localparam logic [3:0] C_SEL_DUCKR   = 4'b1011;

  state_t      state_q, state_d;
  logic [7:0]  h_q, h_d;
  logic [6:0]  v_q, v_d;
  logic [3:0]  stepcnt_q, stepcnt_d;
  logic        phase_q, phase_d;
  logic [8:0]  dino_y_q, dino_y_d;
  logic [3:0]  anim_q, anim_d;

  logic signed [8:0] next_h;
  logic        [6:0] v_dec;

  assign next_h = $signed({1'b0, h_q}) + $signed({{2{v_q[6]}}, v_q});
  assign v_dec  = v_q - (duck_btn ? 7'd3 : 7'd1);

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    stepcnt_d = stepcnt_q;
    phase_d   = phase_q;
    dino_y_d  = dino_y_q;
    anim_d    = anim_q;

    if (frame_tick) begin
      if (state_q == S_RUN || state_q == S_DUCK) begin
        if (stepcnt_q == STEP_FRAMES - 4'd1) begin
          stepcnt_d = 4'd0;
          phase_d   = ~phase_q;
        end else begin
          stepcnt_d = stepcnt_q + 4'd1;
        end
      end

      // collide outranks every other input in the three live states
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (collide) begin
            state_d = S_DEAD;
          end else if (jump_btn) begin
            state_d = S_JUMP;
            v_d     = JUMP_V;
            h_d     = 8'd0;
          end else if (duck_btn) begin
            state_d = S_DUCK;
          end
        end
        S_JUMP: begin
          if (collide) begin
            state_d = S_DEAD;
          end else if (next_h <= 9'sd0 && v_q[6]) begin
            h_d     = 8'd0;
            v_d     = 7'd0;
            state_d = duck_btn ? S_DUCK : S_RUN;
          end else begin
            h_d = next_h[7:0];
            v_d = v_dec;
          end
        end
        S_DUCK: begin
          if (collide) begin
            state_d = S_DEAD;
          end else if (jump_btn) begin
            state_d = S_JUMP;
            v_d     = JUMP_V;
            h_d     = 8'd0;
          end else if (!duck_btn) begin
            state_d = S_RUN;
          end
        end
        S_DEAD: begin
          if (start) begin
            state_d   = S_RUN;
            h_d       = 8'd0;
            v_d       = 7'd0;
            stepcnt_d = 4'd0;
            phase_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // outputs follow the state being entered, so they register with it
      case (state_d)
        S_RUN: begin
          dino_y_d = GROUND_Y;
          anim_d   = phase_d ? C_SEL_RUNR : C_SEL_RUNL;
        end
        S_JUMP: begin
          dino_y_d = GROUND_Y - {1'b0, h_d};
          anim_d   = C_SEL_DEFAULT;
        end
        S_DUCK: begin
          dino_y_d = GROUND_Y + DUCK_OFFSET;
          anim_d   = phase_d ? C_SEL_DUCKR : C_SEL_DUCKL;
        end
        S_DEAD: begin
          anim_d = C_SEL_DEAD;
        end
        default: begin
          dino_y_d = GROUND_Y;
          anim_d   = C_SEL_DEFAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      h_q       <= 8'd0;
      v_q       <= 7'd0;
      stepcnt_q <= 4'd0;
      phase_q   <= 1'b0;
      dino_y_q  <= GROUND_Y;
      anim_q    <= C_SEL_DEFAULT;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      stepcnt_q <= stepcnt_d;
      phase_q   <= phase_d;
      dino_y_q  <= dino_y_d;
      anim_q    <= anim_d;
    end
  end

  assign DinoX      = DINO_X;
  assign DinoY      = dino_y_q;
  assign AnimateSel = anim_q;
  assign is_dead    = (state_q == S_DEAD);
  assign running    = (state_q == S_RUN) || (state_q == S_JUMP) || (state_q == S_DUCK);

endmodule
`default_nettype wire

// File: tb/tb_dino_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dino_motion_ctrl: scoreboard bench against a frame-level dino model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dino_motion_ctrl;

  localparam int C_GY   = 300;
  localparam int C_DOFF = 34;
  localparam int C_JV   = 20;
  localparam int C_SF   = 6;
  localparam int C_DX   = 40;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_JUMP = 2;
  localparam int M_DUCK = 3;
  localparam int M_DEAD = 4;

  typedef struct {
    int y;
    int sel;
    bit dead;
    bit run;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       jump_btn;
  logic       duck_btn;
  logic       collide;
  logic [9:0] DinoX;
  logic [8:0] DinoY;
  logic [3:0] AnimateSel;
  logic       is_dead;
  logic       running;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int m_mode, m_h, m_v, m_step, m_phase, m_y;

  always #5 clk = ~clk;

  dino_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .jump_btn   (jump_btn),
    .duck_btn   (duck_btn),
    .collide    (collide),
    .DinoX      (DinoX),
    .DinoY      (DinoY),
    .AnimateSel (AnimateSel),
    .is_dead    (is_dead),
    .running    (running)
  );

  function automatic exp_t reset_exp();
    exp_t e;
    e.y = C_GY; e.sel = 0; e.dead = 1'b0; e.run = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_h = 0; m_v = 0; m_step = 0; m_phase = 0; m_y = C_GY;
  endtask

  task automatic model_step(input bit s, input bit j, input bit d, input bit c);
    int prev = m_mode;
    int nh;
    if (prev == M_RUN || prev == M_DUCK) begin
      m_step++;
      if (m_step == C_SF) begin
        m_step  = 0;
        m_phase = 1 - m_phase;
      end
    end
    case (prev)
      M_IDLE: if (s) m_mode = M_RUN;
      M_RUN: begin
        if (c) m_mode = M_DEAD;
        else if (j) begin m_mode = M_JUMP; m_h = 0; m_v = C_JV; end
        else if (d) m_mode = M_DUCK;
      end
      M_JUMP: begin
        nh = m_h + m_v;
        if (c) m_mode = M_DEAD;
        else if (nh <= 0 && m_v < 0) begin
          m_h = 0; m_v = 0;
          m_mode = d ? M_DUCK : M_RUN;
        end else begin
          m_h = nh;
          m_v = m_v - (d ? 3 : 1);
        end
      end
      M_DUCK: begin
        if (c) m_mode = M_DEAD;
        else if (j) begin m_mode = M_JUMP; m_h = 0; m_v = C_JV; end
        else if (!d) m_mode = M_RUN;
      end
      default: begin
        if (s) begin
          m_mode = M_RUN; m_h = 0; m_v = 0; m_step = 0; m_phase = 0;
        end
      end
    endcase
    if (m_mode == M_JUMP)      m_y = C_GY - m_h;
    else if (m_mode == M_DUCK) m_y = C_GY + C_DOFF;
    else if (m_mode != M_DEAD) m_y = C_GY;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.y    = m_y;
    e.dead = (m_mode == M_DEAD);
    e.run  = (m_mode == M_RUN || m_mode == M_JUMP || m_mode == M_DUCK);
    case (m_mode)
      M_RUN:   e.sel = m_phase ? 7 : 3;
      M_DUCK:  e.sel = m_phase ? 11 : 2;
      M_DEAD:  e.sel = 1;
      default: e.sel = 0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input exp_t e);
    checks++;
    if (DinoY !== 9'(e.y) || AnimateSel !== 4'(e.sel) || is_dead !== e.dead ||
        running !== e.run || DinoX !== 10'(C_DX)) begin
      errors++;
      $display("FAIL %s @%0t: got DinoY=%0d sel=%b dead=%b run=%b X=%0d, want DinoY=%0d sel=%b dead=%b run=%b X=%0d",
               tag, $time, DinoY, AnimateSel, is_dead, running, DinoX,
               e.y, 4'(e.sel), e.dead, e.run, C_DX);
    end
  endtask

  // Monitor: pops one expectation per frame tick, otherwise demands held outputs.
  initial begin : monitor
    exp_t cur;
    bit   tick_s;
    cur = reset_exp();
    forever begin
      @(posedge clk);
      tick_s = frame_tick;
      #1;
      if (!rst) begin
        cur = reset_exp();
        check("reset", cur);
      end else if (tick_s) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow @%0t: got tick with empty queue, want queued expectation", $time);
        end else begin
          cur = q.pop_front();
          check("tick", cur);
        end
      end else begin
        check("hold", cur);
      end
    end
  end

  always @(negedge rst) begin
    #1;
    check("async_reset", reset_exp());
  end

  task automatic do_tick(input bit s, input bit j, input bit d, input bit c);
    @(negedge clk);
    start = s; jump_btn = j; duck_btn = d; collide = c;
    frame_tick = 1'b1;
    model_step(s, j, d, c);
    q.push_back(model_out());
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic noise(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b0;
      start    = 1'($urandom_range(1));
      jump_btn = 1'($urandom_range(1));
      duck_btn = 1'($urandom_range(1));
      collide  = 1'($urandom_range(1));
    end
  endtask

  initial begin : stim
    rst = 1'b0; frame_tick = 1'b0;
    start = 1'b0; jump_btn = 1'b0; duck_btn = 1'b0; collide = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    do_tick(0, 0, 0, 0);
    do_tick(1, 0, 0, 0);
    repeat (13) do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 0);
    repeat (44) do_tick(0, 0, 0, 0);
    repeat (14) do_tick(0, 0, 1, 0);
    do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 0);
    repeat (10) do_tick(0, 0, 0, 0);
    repeat (30) do_tick(0, 0, 1, 0);
    do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 0);
    repeat (5) do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 1);
    repeat (3) do_tick(0, 1, 1, 0);
    do_tick(1, 0, 0, 0);
    repeat (45) do_tick(0, 1, 0, 0);

    noise(1000);

    do_tick(0, 1, 0, 0);
    repeat (8) do_tick(0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_tick(1, 0, 0, 0);

    repeat (1500) begin
      do_tick($urandom_range(99) < 10, $urandom_range(99) < 20,
              $urandom_range(99) < 30, $urandom_range(99) < 3);
      noise($urandom_range(2));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dino_motion_ctrl.md
# dino_motion_ctrl

Per-frame motion and animation controller for the dinosaur sprite. Turns player buttons, start, and collision events into the sprite position (`DinoX`, `DinoY`) and the 4-bit `AnimateSel` code consumed by the dino pixel/ROM lookup stage. It sits between the input debouncers and collision logic on one side and the sprite renderer on the other. All motion advances once per video frame.

## Interface
- `DINO_X`, default 10'd40: fixed left edge of the sprite, in pixels.
- `GROUND_Y`, default 9'd300: top row of the standing sprite when on the ground.
- `DUCK_OFFSET`, default 9'd34: standing height 94 minus ducking height 60. Keeps the feet on the ground while ducking.
- `JUMP_V`, default 7'd20: initial upward velocity, in pixels per frame.
- `STEP_FRAMES`, default 4'd6: frames per leg-animation phase.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `start` in 1: level input; starts or restarts the game.
- `jump_btn` in 1: level input, debounced.
- `duck_btn` in 1: level input, debounced.
- `collide` in 1: level input from collision logic; the dino overlaps an obstacle.
- `DinoX` out 10: sprite left edge; always equals `DINO_X`.
- `DinoY` out 9: sprite top row; registered.
- `AnimateSel` out 4: sprite select; registered. Codes:
  - Default 0000
  - Dead 0001
  - RunL 0011
  - RunR 0111
  - DuckL 0010
  - DuckR 1011
- `is_dead` out 1: high while in the DEAD state.
- `running` out 1: high in RUN, JUMP and DUCK; used for score enable.

## Operation
- State and counters change only in the `clk` cycle where `frame_tick` is high. Button and collide levels are sampled in that cycle only.
- Registers:
  - FSM state.
  - `h`: 8-bit unsigned height above ground.
  - `v`: 7-bit signed velocity, positive is up.
  - `stepcnt`: 4-bit frame counter.
  - `phase`: 1-bit leg phase.
- States:
  - **IDLE**: `AnimateSel`=Default, `DinoY`=`GROUND_Y`. Moves to RUN on `start`.
  - **RUN**: `AnimateSel` is RunL when `phase`=0, RunR when `phase`=1. `DinoY`=`GROUND_Y`.
    - `jump_btn` → JUMP, with `v`=`JUMP_V` and `h`=0.
    - Otherwise `duck_btn` → DUCK.
  - **JUMP**: `AnimateSel`=Default, `DinoY`=`GROUND_Y`−`h`.
    - Each tick, next_h = `h`+`v`, computed as 9-bit signed.
    - Each tick `v` decreases by 1; by 3 while `duck_btn` is high (fast fall).
    - If next_h ≤ 0 and `v` < 0, the dino lands: `h`=0, `v`=0. It goes to DUCK if `duck_btn` is high, else RUN.
    - Otherwise `h` = next_h[7:0].
  - **DUCK**: `AnimateSel` is DuckL when `phase`=0, DuckR when `phase`=1. `DinoY`=`GROUND_Y`+`DUCK_OFFSET`.
    - `jump_btn` → JUMP.
    - `duck_btn` low → RUN.
  - **DEAD**: `AnimateSel`=Dead. `DinoY` is frozen at its value on entry.
    - `start` → RUN with `h`=0, `v`=0, `stepcnt`=0, `phase`=0.
- `collide` has highest priority. In RUN, JUMP or DUCK it forces DEAD on the same tick, overriding `jump_btn`, `duck_btn` and landing.
- Other priorities:
  - In RUN, `jump_btn` beats `duck_btn`.
  - `start` is ignored outside IDLE and DEAD.
  - A held `jump_btn` re-triggers a jump on the first RUN tick after landing.
- Leg animation:
  - `stepcnt` counts ticks in RUN and DUCK.
  - When `stepcnt`=`STEP_FRAMES`−1, it wraps to 0 and `phase` toggles.
  - `stepcnt` and `phase` hold their values during JUMP and DEAD.
- Width rules:
  - Peak height is `JUMP_V`·(`JUMP_V`+1)/2 = 210 with defaults. It must stay ≤ 255 and ≤ `GROUND_Y`; this is a parameter constraint, not checked in hardware.
  - `v` never underflows below −64 with the defaults.

## Timing
- Reset (asynchronous, `rst`=0) sets:
  - state IDLE; `h`, `v`, `stepcnt`, `phase` all 0.
  - `DinoY`=`GROUND_Y`, `AnimateSel`=0000, `DinoX`=`DINO_X`.
  - `is_dead`=0, `running`=0.
- Reset asserted mid-jump returns the block to IDLE immediately. No frame-boundary wait.
- Latency: outputs reflect a tick's decision on the clock edge after the `frame_tick` cycle, i.e. 1 cycle.
- Outputs are stable for the rest of the frame.
- With `frame_tick` low, all outputs hold regardless of inputs.

## Test plan
- **Reset and start:** `rst` low then high → `DinoY`=300, `AnimateSel`=0000. `start` on tick 1 → `AnimateSel`=0011 after that tick, `running`=1.
- **Running legs:** stay in RUN for 12 ticks → `AnimateSel` is 0011 for 6 ticks, then 0111 for 6 ticks, then 0011.
- **Jump arc:** `jump_btn` for one tick from RUN →
  - `DinoY` reads 300, 280, 261, 243, … after successive ticks.
  - Minimum is `DinoY`=90 (h=210).
  - The dino is back at 300 with `AnimateSel` RunL/RunR 41 ticks after takeoff.
- **Duck and fast fall:**
  - `duck_btn` in RUN → `DinoY`=334, `AnimateSel`=0010 alternating with 1011.
  - Duck held mid-jump → earlier landing, and DUCK state on landing.
- **Collision priority:** `collide` and `jump_btn` high on the same tick during JUMP at h=100 →
  - `AnimateSel`=0001, `DinoY`=200 frozen, `is_dead`=1.
  - Later `start` → RUN at `DinoY`=300.
- **Gating:** toggle every input with `frame_tick` low for 1000 cycles → no output change.
